rv32i_pipeline_ctrl: RTL and testbench

- Hazard and sequencing controller for the RV32I fetch/decode/execute pipeline.
- Generates the decoder's `stall` and `update_pc` controls from three conditions: load-use hazards, data-memory wait states and taken branches/jumps/traps.
- Sequences the pipeline flush that follows a redirect.
- Keeps saturating performance counters of lost cycles for debug.

---
 rtl/rv32i_pipeline_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_rv32i_pipeline_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_pipeline_ctrl.sv
// Hazard and sequencing controller for the RV32I fetch/decode/execute pipeline.
// Freezes fetch/decode on load-use hazards and data-memory wait states,
// sequences the decode flush after a taken branch, jump or trap, and keeps
// saturating debug counters of stalled cycles and redirects.
module rv32i_pipeline_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [4:0]           id_rs1,
  input  logic [4:0]           id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic                 ex_load,
  input  logic [4:0]           ex_rd,
  input  logic                 mem_req,
  input  logic                 mem_ack,
  input  logic                 redirect,
  output logic                 stall,
  output logic                 update_pc,
  output logic                 bubble,
  output logic                 mem_err,
  output logic [1:0]           state_o,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HAZ   = 2'd1,
    MEMW  = 2'd2,
    FLUSH = 2'd3
  } state_e;

  // The flush counter counts down to zero, so it is loaded with one less
  // than the number of update_pc cycles wanted.
  localparam logic [2:0]           FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [8:0]           TMO_LIMIT    = 9'(MEM_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX      = '1;

  state_e               state_q, state_d;
  logic [2:0]           flushCnt_q, flushCnt_d;
  logic [7:0]           tmoCnt_q, tmoCnt_d;
  logic [8:0]           tmoNext;
  logic                 updatePc_q, updatePc_d;
  logic                 bubble_q, bubble_d;
  logic                 memErr_q, memErr_d;
  logic [CNT_WIDTH-1:0] stallCycles_q, stallCycles_d;
  logic [CNT_WIDTH-1:0] flushCount_q, flushCount_d;
  logic                 loadUse;
  logic                 memWait;
  logic                 stallRaw;
  logic                 redirectTaken;

  // Hazard detection: x0 is never a real dependency, and an operand the
  // decode instruction does not read cannot hazard.
  always_comb begin
    loadUse = ex_load & (|ex_rd) &
              ((id_rs1_used & (ex_rd == id_rs1)) |
               (id_rs2_used & (ex_rd == id_rs2)));
    memWait = mem_req & ~mem_ack;
  end

  // Next-state decode; a redirect outranks a memory wait, which outranks a
  // load-use hazard.
  always_comb begin
    state_d       = state_q;
    flushCnt_d    = flushCnt_q;
    tmoCnt_d      = tmoCnt_q;
    updatePc_d    = 1'b0;
    bubble_d      = 1'b0;
    memErr_d      = 1'b0;
    stallRaw      = 1'b0;
    redirectTaken = 1'b0;
    tmoNext       = {1'b0, tmoCnt_q} + 9'd1;
    case (state_q)
      RUN: begin
        if (redirect) begin
          redirectTaken = 1'b1;
          state_d       = FLUSH;
          flushCnt_d    = FLUSH_RELOAD;
          updatePc_d    = 1'b1;
        end else if (memWait) begin
          stallRaw = 1'b1;
          state_d  = MEMW;
          tmoCnt_d = 8'd1;
        end else if (loadUse) begin
          stallRaw = 1'b1;
          state_d  = HAZ;
          bubble_d = 1'b1;
        end
      end
      HAZ: begin
        if (redirect) begin
          redirectTaken = 1'b1;
          state_d       = FLUSH;
          flushCnt_d    = FLUSH_RELOAD;
          updatePc_d    = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      MEMW: begin
        // Execute is frozen here, so a redirect cannot be genuine and is ignored.
        stallRaw = ~mem_ack;
        if (mem_ack) begin
          state_d  = RUN;
          tmoCnt_d = 8'd0;
        end else if (tmoNext >= TMO_LIMIT) begin
          state_d  = RUN;
          tmoCnt_d = 8'd0;
          memErr_d = 1'b1;
          bubble_d = 1'b1;
        end else begin
          tmoCnt_d = tmoNext[7:0];
        end
      end
      FLUSH: begin
        // Decode content is being thrown away, so hazards do not matter here.
        if (redirect) begin
          redirectTaken = 1'b1;
          flushCnt_d    = FLUSH_RELOAD;
          updatePc_d    = 1'b1;
        end else if (flushCnt_q == 3'd0) begin
          state_d = RUN;
        end else begin
          flushCnt_d = flushCnt_q - 3'd1;
          updatePc_d = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Stall is combinational but must read as zero while reset is held.
  always_comb begin
    stall = reset_n & stallRaw;
  end

  // Saturating performance counters never wrap back to zero.
  always_comb begin
    stallCycles_d = stallCycles_q;
    flushCount_d  = flushCount_q;
    if (stall && (stallCycles_q != CNT_MAX)) begin
      stallCycles_d = stallCycles_q + 1'b1;
    end
    if (redirectTaken && (flushCount_q != CNT_MAX)) begin
      flushCount_d = flushCount_q + 1'b1;
    end
  end

  // State, sequencing counters, registered outputs and performance counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RUN;
      flushCnt_q    <= 3'd0;
      tmoCnt_q      <= 8'd0;
      updatePc_q    <= 1'b0;
      bubble_q      <= 1'b0;
      memErr_q      <= 1'b0;
      stallCycles_q <= '0;
      flushCount_q  <= '0;
    end else begin
      state_q       <= state_d;
      flushCnt_q    <= flushCnt_d;
      tmoCnt_q      <= tmoCnt_d;
      updatePc_q    <= updatePc_d;
      bubble_q      <= bubble_d;
      memErr_q      <= memErr_d;
      stallCycles_q <= stallCycles_d;
      flushCount_q  <= flushCount_d;
    end
  end

  // Drive the ports straight from the registers.
  always_comb begin
    update_pc    = updatePc_q;
    bubble       = bubble_q;
    mem_err      = memErr_q;
    state_o      = state_q;
    stall_cycles = stallCycles_q;
    flush_count  = flushCount_q;
  end

endmodule

// File: tb/tb_rv32i_pipeline_ctrl.sv
// Scoreboard bench for rv32i_pipeline_ctrl: a behavioural model expressed as
// remaining-flush and cycles-waited counts predicts each cycle's outputs,
// which a separate monitor compares against the DUT on the falling edge.
module tb_rv32i_pipeline_ctrl;

  localparam int FC   = 2;
  localparam int MT   = 4;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_rs1_used, id_rs2_used, ex_load;
  logic          mem_req, mem_ack, redirect;
  logic          stall, update_pc, bubble, mem_err;
  logic [1:0]    state_o;
  logic [CW-1:0] stall_cycles, flush_count;

  typedef struct {
    logic       stall;
    logic       upd;
    logic       bub;
    logic       err;
    logic [1:0] st;
    int         sc;
    int         fc;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;
  int   checks   = 0;
  int   errors   = 0;
  int   cycleNum = 0;

  // Reference model state
  int   flushLeft, waitCnt, stallTotal, flushTotal;
  bit   waiting, hazNow, bubbleNow, errNow;

  rv32i_pipeline_ctrl #(
    .FLUSH_CYCLES(FC),
    .MEM_TIMEOUT (MT),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_load     (ex_load),
    .ex_rd       (ex_rd),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .redirect    (redirect),
    .stall       (stall),
    .update_pc   (update_pc),
    .bubble      (bubble),
    .mem_err     (mem_err),
    .state_o     (state_o),
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got %0d want %0d", name, cycleNum, got, want);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic modelReset();
    flushLeft  = 0;
    waitCnt    = 0;
    stallTotal = 0;
    flushTotal = 0;
    waiting    = 0;
    hazNow     = 0;
    bubbleNow  = 0;
    errNow     = 0;
  endtask

  task automatic pushZeros();
    exp_t e;
    e.stall = 0; e.upd = 0; e.bub = 0; e.err = 0; e.st = 2'd0; e.sc = 0; e.fc = 0;
    expQ.push_back(e);
  endtask

  // One clock cycle: drive inputs, predict this cycle's outputs, advance model.
  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic ld,
                               input logic [4:0] rd, input logic req,
                               input logic ack, input logic redir);
    exp_t e;
    bit   lu, mw, st, nextHaz;
    @(posedge clk);
    #1;
    reset_n     = 1'b1;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rs1_used = u1;
    id_rs2_used = u2;
    ex_load     = ld;
    ex_rd       = rd;
    mem_req     = req;
    mem_ack     = ack;
    redirect    = redir;

    lu = ld && (rd != 0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
    mw = req && !ack;
    if (waiting)                    st = !ack;
    else if (flushLeft > 0 || hazNow) st = 0;
    else if (redir)                 st = 0;
    else                            st = mw || lu;

    e.stall = st;
    e.upd   = (flushLeft > 0);
    e.bub   = bubbleNow;
    e.err   = errNow;
    e.st    = (flushLeft > 0) ? 2'd3 : waiting ? 2'd2 : hazNow ? 2'd1 : 2'd0;
    e.sc    = stallTotal;
    e.fc    = flushTotal;
    expQ.push_back(e);

    if (st) stallTotal = sat(stallTotal);
    bubbleNow = 0;
    errNow    = 0;
    nextHaz   = 0;
    if (waiting) begin
      if (ack) begin
        waiting = 0;
      end else if (waitCnt + 1 >= MT) begin
        waiting   = 0;
        bubbleNow = 1;
        errNow    = 1;
      end else begin
        waitCnt++;
      end
    end else if (redir) begin
      flushLeft  = FC;
      flushTotal = sat(flushTotal);
    end else if (flushLeft > 0) begin
      flushLeft--;
    end else if (hazNow) begin
      nextHaz = 0;
    end else if (mw) begin
      waiting = 1;
      waitCnt = 1;
    end else if (lu) begin
      nextHaz   = 1;
      bubbleNow = 1;
    end
    hazNow = nextHaz;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Drop reset with a memory wait pending; outputs must clear at once.
  task automatic applyReset();
    @(posedge clk);
    #1;
    mem_req  = 1'b1;
    mem_ack  = 1'b0;
    redirect = 1'b0;
    reset_n  = 1'b0;
    #1;
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_update_pc", update_pc, 0);
    checkOutput("rst_bubble", bubble, 0);
    checkOutput("rst_mem_err", mem_err, 0);
    checkOutput("rst_state", state_o, 0);
    checkOutput("rst_stall_cycles", stall_cycles, 0);
    checkOutput("rst_flush_count", flush_count, 0);
    modelReset();
    pushZeros();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      pushZeros();
    end
  endtask

  // Monitor: compare each predicted cycle against the DUT on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        monE = expQ.pop_front();
        cycleNum++;
        checkOutput("stall", stall, monE.stall);
        checkOutput("update_pc", update_pc, monE.upd);
        checkOutput("bubble", bubble, monE.bub);
        checkOutput("mem_err", mem_err, monE.err);
        checkOutput("state", state_o, monE.st);
        checkOutput("stall_cycles", stall_cycles, monE.sc);
        checkOutput("flush_count", flush_count, monE.fc);
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Stimulus: directed scenarios followed by randomized traffic
  initial begin
    reset_n = 1'b0;
    id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    ex_load = 0; ex_rd = 0; mem_req = 0; mem_ack = 0; redirect = 0;
    modelReset();
    repeat (3) @(posedge clk);
    $display("[TB] directed scenarios");

    applyStimulus(5, 0, 1, 0, 1, 5, 0, 0, 0);
    idle(3);
    applyStimulus(0, 0, 1, 1, 1, 0, 0, 0, 0);
    applyStimulus(0, 7, 1, 0, 1, 7, 0, 0, 0);
    idle(2);

    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(2);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(1);

    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(3);

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(4);

    applyStimulus(3, 0, 1, 0, 1, 3, 0, 0, 1);
    idle(4);

    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyReset();
    idle(3);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) applyReset();
      applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                    ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 40),
                    ($urandom_range(0, 99) < 8));
    end
    idle(2);

    @(negedge clk);
    #1;
    checkOutput("queue_drained", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
